// File: rtl/huffman_freq_sort.sv
// huffman_freq_sort: sorts a symbol frequency histogram into ascending-count
// order (ties by ascending symbol) and streams the non-zero pairs downstream.
//
// Ports:
//   clk         system clock
//   reset       synchronous active-low reset
//   flag_accum  start request from the read stage, honoured only in IDLE
//   curr_count  histogram, held stable by upstream until sort_done
//   out_ready   downstream accepts the current pair
//   out_valid   out_symbol/out_count carry a valid pair
//   out_symbol  symbol index of the current pair
//   out_count   frequency of the current pair
//   out_last    current pair is the final one
//   leaf_num    number of non-zero bins found by the last scan
//   busy        scan or emit in progress
//   sort_done   one-cycle pulse once the stream is complete
module huffman_freq_sort #(
    parameter int unsigned NUM_SYM = 128,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flag_accum,
    input  logic [NUM_SYM-1:0][CNT_W-1:0]   curr_count,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [$clog2(NUM_SYM)-1:0]      out_symbol,
    output logic [CNT_W-1:0]                out_count,
    output logic                            out_last,
    output logic [$clog2(NUM_SYM+1)-1:0]    leaf_num,
    output logic                            busy,
    output logic                            sort_done
);

    localparam int unsigned SYM_W  = $clog2(NUM_SYM);
    localparam int unsigned LEAF_W = $clog2(NUM_SYM + 1);

    typedef struct packed {
        logic [SYM_W-1:0] sym;
        logic [CNT_W-1:0] cnt;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t               state;
    logic [SYM_W-1:0]     idx;       // scan index in SCAN, list read pointer in EMIT
    entry_t               list_q   [NUM_SYM];
    entry_t               list_ins [NUM_SYM];
    logic [NUM_SYM-1:0]   le;
    logic [CNT_W-1:0]     cur_cnt;
    logic                 hit;
    logic [LEAF_W-1:0]    leaf_next;
    logic [SYM_W-1:0]     idx_nxt;
    entry_t               new_entry;

    // Current bin under scan and derived insert quantities
    always_comb begin
        cur_cnt   = curr_count[idx];
        hit       = (cur_cnt != '0);
        leaf_next = leaf_num + LEAF_W'(hit);
        idx_nxt   = idx + SYM_W'(1);
        new_entry = '{sym: idx, cnt: cur_cnt};
    end

    // Stored entries that sort at or before the new count; a prefix because the list is sorted
    always_comb begin
        le = '0;
        for (int j = 0; j < NUM_SYM; j++) begin
            le[j] = (LEAF_W'(j) < leaf_num) && (list_q[j].cnt <= cur_cnt);
        end
    end

    // Parallel insert: keep the prefix, drop the new entry at the boundary, shift the rest up
    always_comb begin
        for (int j = 0; j < NUM_SYM; j++) begin
            list_ins[j] = list_q[j];
        end
        if (hit) begin
            list_ins[0] = le[0] ? list_q[0] : new_entry;
            for (int j = 1; j < NUM_SYM; j++) begin
                if (le[j]) begin
                    list_ins[j] = list_q[j];
                end else if (le[j-1]) begin
                    list_ins[j] = new_entry;
                end else begin
                    list_ins[j] = list_q[j-1];
                end
            end
        end
    end

    // Control FSM with registered outputs; the sort_done cycle is spent in SCAN/EMIT before IDLE
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            leaf_num   <= '0;
            out_valid  <= 1'b0;
            out_symbol <= '0;
            out_count  <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            sort_done  <= 1'b0;
            for (int j = 0; j < NUM_SYM; j++) begin
                list_q[j] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (flag_accum) begin
                        state    <= SCAN;
                        busy     <= 1'b1;
                        idx      <= '0;
                        leaf_num <= '0;
                        for (int j = 0; j < NUM_SYM; j++) begin
                            list_q[j] <= '0;
                        end
                    end
                end
                SCAN: begin
                    if (sort_done) begin
                        sort_done <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        for (int j = 0; j < NUM_SYM; j++) begin
                            list_q[j] <= list_ins[j];
                        end
                        leaf_num <= leaf_next;
                        idx      <= idx_nxt;
                        if (idx == SYM_W'(NUM_SYM - 1)) begin
                            if (leaf_next != '0) begin
                                // idx wraps to 0, which is the first list entry to present
                                state      <= EMIT;
                                out_valid  <= 1'b1;
                                out_symbol <= list_ins[0].sym;
                                out_count  <= list_ins[0].cnt;
                                out_last   <= (leaf_next == LEAF_W'(1));
                            end else begin
                                sort_done <= 1'b1;
                            end
                        end
                    end
                end
                EMIT: begin
                    if (sort_done) begin
                        sort_done <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (out_valid && out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            sort_done <= 1'b1;
                        end else begin
                            idx        <= idx_nxt;
                            out_symbol <= list_q[idx_nxt].sym;
                            out_count  <= list_q[idx_nxt].cnt;
                            out_last   <= ((LEAF_W'(idx) + LEAF_W'(2)) == leaf_num);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_freq_sort.sv
// Directed testbench for huffman_freq_sort: hand-computed sorted streams,
// empty histogram, stalls, mid-scan reset and ignored start pulses.
module tb_huffman_freq_sort;

    logic                 clk;
    logic                 reset;
    logic                 flag_accum;
    logic [127:0][15:0]   curr_count;
    logic                 out_ready;
    logic                 out_valid;
    logic [6:0]           out_symbol;
    logic [15:0]          out_count;
    logic                 out_last;
    logic [7:0]           leaf_num;
    logic                 busy;
    logic                 sort_done;

    int errors = 0;
    int checks = 0;
    int exp_sym[$];
    int exp_cnt[$];

    huffman_freq_sort #(.NUM_SYM(128), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .flag_accum (flag_accum),
        .curr_count (curr_count),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_symbol (out_symbol),
        .out_count  (out_count),
        .out_last   (out_last),
        .leaf_num   (leaf_num),
        .busy       (busy),
        .sort_done  (sort_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a sort, run the scan, then consume and check the stream against exp_sym/exp_cnt.
    // mode 0: out_ready held high; mode 1: out_ready 1,0,0 repeating.
    task automatic run(input string name, input int n, input int mode, input bit pulse);
        int k;
        int cyc;
        flag_accum = 1'b1;
        tick();
        flag_accum = 1'b0;
        chk({name, "_busy_start"}, 32'(busy), 32'd1);
        for (int i = 0; i < 128; i++) begin
            flag_accum = pulse && (i == 50);
            tick();
        end
        flag_accum = 1'b0;
        if (n == 0) begin
            chk({name, "_empty_done"}, 32'(sort_done), 32'd1);
            chk({name, "_empty_valid"}, 32'(out_valid), 32'd0);
            chk({name, "_empty_busy"}, 32'(busy), 32'd1);
            chk({name, "_empty_leaf"}, 32'(leaf_num), 32'd0);
            tick();
            chk({name, "_empty_done_clr"}, 32'(sort_done), 32'd0);
            chk({name, "_empty_idle"}, 32'(busy), 32'd0);
            return;
        end
        chk({name, "_leaf"}, 32'(leaf_num), 32'(n));
        k = 0;
        cyc = 0;
        while (k < n && cyc < 4 * n + 8) begin
            out_ready  = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            flag_accum = pulse && (cyc == 1);
            chk({name, "_valid"}, 32'(out_valid), 32'd1);
            chk({name, "_sym"}, 32'(out_symbol), 32'(exp_sym[k]));
            chk({name, "_cnt"}, 32'(out_count), 32'(exp_cnt[k]));
            chk({name, "_last"}, 32'(out_last), 32'(k == n - 1));
            chk({name, "_no_done"}, 32'(sort_done), 32'd0);
            if (out_ready) k++;
            tick();
            cyc++;
        end
        flag_accum = 1'b0;
        out_ready  = 1'b0;
        chk({name, "_handshakes"}, 32'(k), 32'(n));
        chk({name, "_end_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_done"}, 32'(sort_done), 32'd1);
        tick();
        chk({name, "_done_clr"}, 32'(sort_done), 32'd0);
        chk({name, "_idle"}, 32'(busy), 32'd0);
        chk({name, "_leaf_hold"}, 32'(leaf_num), 32'(n));
    endtask

    initial begin
        reset      = 1'b0;
        flag_accum = 1'b0;
        out_ready  = 1'b0;
        curr_count = '0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sym", 32'(out_symbol), 32'd0);
        chk("rst_cnt", 32'(out_count), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_leaf", 32'(leaf_num), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(sort_done), 32'd0);
        reset = 1'b1;
        tick();

        // Three entries with a tie at count 5
        curr_count      = '0;
        curr_count[97]  = 16'd5;
        curr_count[98]  = 16'd2;
        curr_count[99]  = 16'd5;
        exp_sym = {98, 97, 99};
        exp_cnt = {2, 5, 5};
        run("three", 3, 0, 1'b0);

        // Empty histogram
        curr_count = '0;
        exp_sym = {};
        exp_cnt = {};
        run("empty", 0, 0, 1'b0);

        // Full histogram, descending counts
        for (int i = 0; i < 128; i++) curr_count[i] = 16'(128 - i);
        exp_sym = {};
        exp_cnt = {};
        for (int k = 0; k < 128; k++) begin
            exp_sym.push_back(127 - k);
            exp_cnt.push_back(k + 1);
        end
        run("full", 128, 0, 1'b0);

        // Saturated counts with back-pressure
        curr_count    = '0;
        curr_count[0] = 16'hFFFF;
        curr_count[5] = 16'd1;
        curr_count[6] = 16'hFFFF;
        exp_sym = {5, 0, 6};
        exp_cnt = {1, 16'hFFFF, 16'hFFFF};
        run("stall", 3, 1, 1'b0);

        // Reset in the middle of a scan, then a clean second run
        curr_count     = '0;
        curr_count[1]  = 16'd7;
        curr_count[20] = 16'd4;
        curr_count[90] = 16'd9;
        flag_accum = 1'b1;
        tick();
        flag_accum = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        reset = 1'b0;
        tick();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_leaf", 32'(leaf_num), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(sort_done), 32'd0);
        reset = 1'b1;
        curr_count     = '0;
        curr_count[10] = 16'd3;
        curr_count[3]  = 16'd3;
        exp_sym = {3, 10};
        exp_cnt = {3, 3};
        tick();
        run("restart", 2, 0, 1'b0);

        // Start pulses during SCAN and EMIT must be ignored
        curr_count     = '0;
        curr_count[40] = 16'd8;
        curr_count[41] = 16'd6;
        exp_sym = {41, 40};
        exp_cnt = {6, 8};
        run("pulse", 2, 0, 1'b1);
        for (int i = 0; i < 135; i++) begin
            chk("pulse_quiet", {30'd0, sort_done, out_valid}, 32'd0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/huffman_freq_sort.md
# huffman_freq_sort

Sorts the 128-entry symbol frequency histogram produced by the read/count stage into ascending-frequency order. It then streams the non-zero (symbol, count) pairs to the Huffman tree builder over a valid/ready handshake. It sits directly downstream of the read stage:
- it is triggered by that stage's `flag_accum`;
- it reads `curr_count` in place, with no snapshot.

## Interface
- `NUM_SYM`, 128, number of symbol bins (symbol width = clog2(NUM_SYM) = 7)
- `CNT_W`, 16, width of each frequency count
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low reset
- `flag_accum`  in  1  histogram complete; start request, sampled only in IDLE
- `curr_count`  in  [NUM_SYM-1:0][CNT_W-1:0]  histogram; upstream holds it stable from `flag_accum` until `sort_done`
- `out_ready`  in  1  downstream accepts current pair
- `out_valid`  out  1  pair on `out_symbol`/`out_count` is valid
- `out_symbol`  out  7  symbol index of current pair
- `out_count`  out  CNT_W  frequency of current pair
- `out_last`  out  1  current pair is the final one
- `leaf_num`  out  8  number of non-zero bins (0..128)
- `busy`  out  1  high in SCAN and EMIT
- `sort_done`  out  1  one-cycle pulse when the stream is complete

## Operation
- States: IDLE, SCAN, EMIT.
- IDLE -> SCAN when `flag_accum`=1. This clears the sorted list, `leaf_num` and the scan index.
- SCAN
  - Visits index i = 0..127, one per cycle.
  - If `curr_count[i]`=0 the bin is skipped.
  - Otherwise the pair (i, c) is inserted into the sorted list at position p = number of stored entries with count <= c. Entries at p and above shift up by one. All of this happens in a single cycle, using parallel compare/shift.
  - Ties are therefore ordered by ascending symbol index (stable sort).
  - `leaf_num` increments on each insertion.
  - After i=127: go to EMIT if `leaf_num`>0. Otherwise pulse `sort_done` and return to IDLE.
- EMIT
  - Presents list entry k, starting at k=0.
  - `out_valid`=1 continuously.
  - `out_last`=1 when k = `leaf_num`-1.
  - A handshake (`out_valid`&&`out_ready`) advances k.
  - The handshake on the last entry causes `out_valid`=0 on the next cycle, a one-cycle `sort_done` pulse on that same cycle, and a return to IDLE.
- `flag_accum` is ignored while `busy`=1.
- Count arithmetic is unsigned CNT_W compare only; no sums are formed. 0xFFFF is a legal count.
- `leaf_num` holds its final value in IDLE until the next start.
- Reset values (all outputs): `out_valid`=0, `out_symbol`=0, `out_count`=0, `out_last`=0, `leaf_num`=0, `busy`=0, `sort_done`=0; state IDLE; list cleared.
- Reset is honoured in any state, including mid-SCAN and mid-EMIT: the next cycle is IDLE with reset values, and no `sort_done` is issued.

## Timing
- `flag_accum` sampled high in IDLE at edge T -> `busy`=1 from T+1. Index i is processed at edge T+1+i.
- Last insertion at edge T+128. EMIT is entered with `out_valid`=1 from T+129 (if `leaf_num`>0).
- Empty histogram: `sort_done` high during cycle T+129, `out_valid` never asserted, `busy` low from T+130.
- `out_symbol`/`out_count`/`out_last` are registered and stable while `out_valid`=1 && `out_ready`=0.
- With `out_ready` held high, one pair per cycle: N pairs occupy cycles T+129..T+128+N, `sort_done` is at T+129+N, and IDLE (accepting a new `flag_accum`) follows at T+130+N.
- Zero-bubble streaming: after a handshake, the next pair is valid on the following cycle.

## Test plan
- Counts: [97]=5, [98]=2, [99]=5, all others 0; `out_ready`=1 -> stream (98,2), (97,5), (99,5); `out_last` only on (99,5); `leaf_num`=3; `sort_done` at T+132.
- All bins 0 -> no `out_valid`; `sort_done` at T+129; `leaf_num`=0.
- `curr_count[i]`=128-i for all i -> 128 pairs, symbols 127 down to 0, counts 1..128; `leaf_num`=128; `out_last` on (0,128).
- Counts [0]=0xFFFF, [5]=1, [6]=0xFFFF; `out_ready` toggling 1,0,0,1,... -> order (5,1), (0,0xFFFF), (6,0xFFFF); outputs stable across stalls; exactly 3 handshakes.
- Assert `reset`=0 at scan index 60, then restart with a new `flag_accum` -> outputs at reset values the next cycle; the second run's stream is correct and contains no stale entries.
- Pulse `flag_accum` during SCAN and again during EMIT -> ignored; a single stream and a single `sort_done` result.
